pwl_vga_bank: RTL



---
 rtl/pwl_vga_bank_if.sv | 25 ++
 rtl/pwl_vga_bank.sv | 103 ++++++++++
 2 files changed

// File: rtl/pwl_vga_bank_if.sv
// Gain-control bus for pwl_vga_bank: ramp request/ack handshake, mute and code readback.
interface pwl_vga_bank_if #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned CODE_W = 4
);
  logic                  gain_req;
  logic [NCH-1:0]        gain_mask;
  logic [CODE_W-1:0]     gain_tgt;
  logic                  mute;
  logic                  busy;
  logic                  gain_ack;
  logic [NCH*CODE_W-1:0] gain_cur;

  // Controller side: issues requests and mute, observes ramp status.
  modport master (
    output gain_req, gain_mask, gain_tgt, mute,
    input  busy, gain_ack, gain_cur
  );

  // VGA bank side.
  modport slave (
    input  gain_req, gain_mask, gain_tgt, mute,
    output busy, gain_ack, gain_cur
  );
endinterface

// File: rtl/pwl_vga_bank.sv
// Bank of NCH variable-gain amplifiers with a shared gain-ramp controller.
// Each pwl signal is modelled as its instantaneous real voltage; the output is
// rescaled whenever the input, the channel code or mute changes.
module pwl_vga_bank #(
  parameter int unsigned NCH        = 2,
  parameter int unsigned CODE_W     = 4,
  parameter real         GAIN_MIN   = 0.5,
  parameter real         GAIN_STEP  = 0.25,
  parameter int unsigned RAMP_DIV   = 4,
  parameter int unsigned RESET_CODE = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  real           in  [NCH],
  output real           out [NCH],
  pwl_vga_bank_if.slave bus
);

  localparam int unsigned CntW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(RAMP_DIV - 1);

  typedef enum logic [0:0] {StIdle, StRamp} state_e;

  state_e            state_q;
  logic              busy_q;
  logic              ack_q;
  logic [CntW-1:0]   cnt_q;
  logic [NCH-1:0]    mask_q;
  logic [CODE_W-1:0] tgt_q;
  logic [CODE_W-1:0] code_q [NCH];
  logic              all_eq;

  // True when every latched channel already sits at the latched target.
  always_comb begin
    all_eq = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (mask_q[i] && (code_q[i] != tgt_q)) all_eq = 1'b0;
    end
  end

  // Ramp controller: latch request, step masked codes one LSB every RAMP_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      mask_q  <= '0;
      tgt_q   <= '0;
      for (int i = 0; i < NCH; i++) code_q[i] <= CODE_W'(RESET_CODE);
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A request during the ack cycle is dropped.
          if (bus.gain_req && !ack_q) begin
            mask_q  <= bus.gain_mask;
            tgt_q   <= bus.gain_tgt;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRamp;
          end
        end
        StRamp: begin
          if (all_eq) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            ack_q   <= 1'b1;
            cnt_q   <= '0;
          end else if (cnt_q == CntMax) begin
            cnt_q <= '0;
            for (int i = 0; i < NCH; i++) begin
              if (mask_q[i] && (code_q[i] != tgt_q)) begin
                code_q[i] <= (code_q[i] < tgt_q) ? code_q[i] + CODE_W'(1)
                                                 : code_q[i] - CODE_W'(1);
              end
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Pack current codes for readback.
  always_comb begin
    bus.gain_cur = '0;
    for (int i = 0; i < NCH; i++) bus.gain_cur[i*CODE_W +: CODE_W] = code_q[i];
  end

  assign bus.busy     = busy_q;
  assign bus.gain_ack = ack_q;

  // Analog scaling path; mute zeroes the output without touching the codes.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      out[i] = bus.mute ? 0.0 : in[i] * (GAIN_MIN + GAIN_STEP * real'(code_q[i]));
    end
  end

endmodule
